// File: rtl/gpio_edge_irq_pkg.sv
// gpio_edge_irq_pkg: register offsets, interrupt index and decode helper for gpio_edge_irq
package gpio_edge_irq_pkg;
  localparam logic [4:0] GPIO_EDGE_RISE_EN  = 5'h00;
  localparam logic [4:0] GPIO_EDGE_FALL_EN  = 5'h04;
  localparam logic [4:0] GPIO_EDGE_PEND     = 5'h08;
  localparam logic [4:0] GPIO_EDGE_DB_LIMIT = 5'h0C;
  localparam logic [4:0] GPIO_EDGE_LEVEL    = 5'h10;
  localparam int GPIO_EDGE_IRQ_BIT = 1;
  function automatic logic wr_hit(logic we, logic [4:0] off, logic [4:0] target);
    return we && (off == target);
  endfunction
endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: one pad's synchroniser, debounce counter and clean level register
module gpio_in_filter #(
  parameter int DB_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pin_i,
  input  logic [DB_W-1:0] limit_i,
  output logic            level_o,
  output logic            upd_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d, s;
  assign s       = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;
  // >= lets a lowered limit release a count already past it on the very next edge
  always_comb begin
    upd_o   = (s != level_q) && (cnt_q >= limit_i);
    level_d = upd_o ? s : level_q;
    cnt_d   = (s == level_q || upd_o) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq: debounced pad levels, per-pin edge detection into W1C pending bits,
// and a single level interrupt, configured through a RIB slave register file
module gpio_edge_irq
  import gpio_edge_irq_pkg::*;
#(
  parameter int NPINS       = 16,
  parameter int DB_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  input  logic [NPINS-1:0] pin_i,
  output logic [NPINS-1:0] level_o,
  output logic             irq_o
);
  logic [NPINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d, pend_q, pend_d;
  logic [NPINS-1:0] upd, ev, clr;
  logic [DB_W-1:0]  lim_q, lim_d;
  logic             irq_q, irq_d;
  logic [4:0]       off;
  logic             unused_bits;
  assign off         = addr_i[4:0];
  assign unused_bits = ^{addr_i[31:5], data_i};
  assign irq_o       = irq_q;
  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    gpio_in_filter #(.DB_W(DB_W), .SYNC_STAGES(SYNC_STAGES)) u_filter (
      .clk     (clk),
      .rst     (rst),
      .pin_i   (pin_i[i]),
      .limit_i (lim_q),
      .level_o (level_o[i]),
      .upd_o   (upd[i])
    );
  end
  // level_o still holds the pre-edge value, so it tells the edge direction
  always_comb begin
    ev        = upd & ((~level_o & rise_en_q) | (level_o & fall_en_q));
    clr       = wr_hit(we_i, off, GPIO_EDGE_PEND) ? data_i[NPINS-1:0] : '0;
    pend_d    = (pend_q & ~clr) | ev;
    irq_d     = |pend_d;
    rise_en_d = wr_hit(we_i, off, GPIO_EDGE_RISE_EN) ? data_i[NPINS-1:0] : rise_en_q;
    fall_en_d = wr_hit(we_i, off, GPIO_EDGE_FALL_EN) ? data_i[NPINS-1:0] : fall_en_q;
    lim_d     = wr_hit(we_i, off, GPIO_EDGE_DB_LIMIT) ? data_i[DB_W-1:0] : lim_q;
    data_o    = (off == GPIO_EDGE_RISE_EN)  ? 32'(rise_en_q) :
                (off == GPIO_EDGE_FALL_EN)  ? 32'(fall_en_q) :
                (off == GPIO_EDGE_PEND)     ? 32'(pend_q)    :
                (off == GPIO_EDGE_DB_LIMIT) ? 32'(lim_q)     :
                (off == GPIO_EDGE_LEVEL)    ? 32'(level_o)   : 32'h0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      lim_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      lim_q     <= lim_d;
      irq_q     <= irq_d;
    end
  end
endmodule
